// File: rtl/ascii_write_queue.sv
// Posted-write queue for text-mode character stores: buffers byte/half/word stores
// and drains them one ASCII byte per cycle into the character RAM while drain_ok is high.
module ascii_write_queue #(
  parameter int DEPTH      = 8,
  parameter int CHAR_CELLS = 4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [12:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_size,
  input  logic        drain_ok,
  input  logic        clr_err,
  output logic        char_we,
  output logic [12:0] char_addr,
  output logic [7:0]  char_data,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        range_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 13 + 32 + 2;
  localparam logic [13:0] CELL_LIMIT = 14'(CHAR_CELLS);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Entry layout: {addr[12:0], data[31:0], size[1:0]}
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  state_t        state_reg;
  logic [1:0]    k_reg;
  logic [12:0]   hold_addr_reg;
  logic [31:0]   hold_data_reg;
  logic [1:0]    hold_size_reg;
  logic          overflow_reg;
  logic          range_err_reg;

  logic          store_req;
  logic          push;
  logic          pop;
  logic          emit_now;
  logic          in_range;
  logic          overflow_hit;
  logic          range_hit;
  logic [1:0]    last_k;
  logic [7:0]    byte_lane [4];

  assign full      = (count_reg == CW'(DEPTH));
  assign busy      = (count_reg != '0) || (state_reg != IDLE);
  assign overflow  = overflow_reg;
  assign range_err = range_err_reg;

  // full is taken from the pre-edge count, so a pop on the same edge never rescues a push
  assign store_req    = wr_en && (wr_size != 2'b00);
  assign push         = store_req && !full;
  assign overflow_hit = store_req && full;
  assign pop          = (state_reg == IDLE) && (count_reg != '0) && drain_ok;

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {wr_addr, wr_data, wr_size};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = hold_data_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (hold_size_reg)
      2'b01:   last_k = 2'd0;
      2'b10:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Cell address wraps at 8192 before the range check, so a top-of-map store can land on cell 0
  assign char_addr = hold_addr_reg + {11'b0, k_reg};
  assign char_data = byte_lane[k_reg];
  assign in_range  = ({1'b0, char_addr} < CELL_LIMIT);
  assign emit_now  = (state_reg == EMIT) && drain_ok;
  assign char_we   = emit_now && in_range;
  assign range_hit = emit_now && !in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      k_reg         <= 2'd0;
      hold_addr_reg <= '0;
      hold_data_reg <= '0;
      hold_size_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {hold_addr_reg, hold_data_reg, hold_size_reg} <= mem[rd_ptr_reg];
            k_reg     <= 2'd0;
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (drain_ok) begin
            k_reg <= k_reg + 2'd1;
            if (k_reg == last_k) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A new error event on the same edge as clr_err keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      if (overflow_hit) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (range_hit) begin
        range_err_reg <= 1'b1;
      end else if (clr_err) begin
        range_err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascii_write_queue.sv
// Self-checking bench: two instances (4800 and 8192 cells) driven in parallel and
// compared every cycle against a queue-based model of the store/drain behaviour.
module tb_ascii_write_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } store_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        drain_ok;
  logic        clr_err;

  logic        c_we      [2];
  logic [12:0] c_addr    [2];
  logic [7:0]  c_data    [2];
  logic        c_full    [2];
  logic        c_busy    [2];
  logic        c_ovf     [2];
  logic        c_rerr    [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit verbose = 1'b1;

  // Model state, one copy per instance
  int     cells [2] = '{4800, 8192};
  store_t mq [2][$];
  store_t cur [2];
  bit     emitting [2];
  int     kidx [2];
  bit     m_ovf [2];
  bit     m_rerr [2];

  always #5 clk = ~clk;

  ascii_write_queue #(.DEPTH(DEPTH), .CHAR_CELLS(4800)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .drain_ok(drain_ok), .clr_err(clr_err),
    .char_we(c_we[0]), .char_addr(c_addr[0]), .char_data(c_data[0]),
    .full(c_full[0]), .busy(c_busy[0]), .overflow(c_ovf[0]), .range_err(c_rerr[0])
  );

  ascii_write_queue #(.DEPTH(DEPTH), .CHAR_CELLS(8192)) dut_wrap (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .drain_ok(drain_ok), .clr_err(clr_err),
    .char_we(c_we[1]), .char_addr(c_addr[1]), .char_data(c_data[1]),
    .full(c_full[1]), .busy(c_busy[1]), .overflow(c_ovf[1]), .range_err(c_rerr[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      emitting[i] = 1'b0;
      kidx[i]     = 0;
      m_ovf[i]    = 1'b0;
      m_rerr[i]   = 1'b0;
      cur[i]      = '0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int a;
      bit e_we;
      logic [7:0] e_data;
      string p;
      p = (i == 0) ? "u4800" : "u8192";
      e_we = 1'b0;
      a = 0;
      e_data = 8'h00;
      if (rst && emitting[i] && drain_ok) begin
        a = (int'(cur[i].addr) + kidx[i]) % 8192;
        e_data = cur[i].data[8*kidx[i] +: 8];
        e_we = (a < cells[i]);
      end
      check_val({p, " char_we"}, 32'(c_we[i]), 32'(e_we));
      if (e_we || !rst) begin
        check_val({p, " char_addr"}, 32'(c_addr[i]), 32'(a));
        check_val({p, " char_data"}, 32'(c_data[i]), 32'(e_data));
      end
      check_val({p, " full"}, 32'(c_full[i]), 32'(mq[i].size() == DEPTH));
      check_val({p, " busy"}, 32'(c_busy[i]), 32'((mq[i].size() != 0) || emitting[i]));
      check_val({p, " overflow"}, 32'(c_ovf[i]), 32'(m_ovf[i]));
      check_val({p, " range_err"}, 32'(c_rerr[i]), 32'(m_rerr[i]));
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit full_b, store, ovf_ev, rng_ev;
      full_b = (mq[i].size() == DEPTH);
      store  = wr_en && (wr_size != 2'b00);
      ovf_ev = store && full_b;
      rng_ev = 1'b0;
      if (emitting[i]) begin
        if (drain_ok) begin
          if ((int'(cur[i].addr) + kidx[i]) % 8192 >= cells[i]) rng_ev = 1'b1;
          kidx[i]++;
          if (kidx[i] == nbytes(cur[i].size)) emitting[i] = 1'b0;
        end
      end else if (mq[i].size() != 0 && drain_ok) begin
        cur[i] = mq[i].pop_front();
        kidx[i] = 0;
        emitting[i] = 1'b1;
      end
      if (store && !full_b) begin
        mq[i].push_back('{addr: wr_addr, data: wr_data, size: wr_size});
        if (verbose && i == 0)
          $display("push  addr=0x%04h data=0x%08h size=%0d", wr_addr, wr_data, wr_size);
      end else if (ovf_ev && verbose && i == 0) begin
        $display("drop  addr=0x%04h (queue full)", wr_addr);
      end
      if (ovf_ev) m_ovf[i] = 1'b1;
      else if (clr_err) m_ovf[i] = 1'b0;
      if (rng_ev) m_rerr[i] = 1'b1;
      else if (clr_err) m_rerr[i] = 1'b0;
    end
  endtask

  // One clock: inputs already driven; check at negedge, advance model at posedge
  task automatic cycle();
    if (!rst) model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst) model_edge();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    wr_en = 1'b0; wr_size = 2'b00; wr_addr = '0; wr_data = '0; clr_err = 1'b0;
  endtask

  task automatic push(input logic [12:0] a, input logic [31:0] d, input logic [1:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = s;
    cycle();
    quiet();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
  endtask

  initial begin
    int wr_pct, drn_pct, sel;
    rst = 1'b0; drain_ok = 1'b0;
    quiet();
    model_reset();
    #1;
    run(3);
    rst = 1'b1;
    run(2);

    $display("scenario: word store drains in 4 cycles");
    drain_ok = 1'b1;
    push(13'h010, 32'h44434241, 2'b11);
    run(8);

    $display("scenario: fill queue with drain held off, overflow on 9th");
    drain_ok = 1'b0;
    for (int j = 0; j < 9; j++) push(13'h100 + 13'(j), 32'h30 + 32'(j), 2'b01);
    run(1);
    drain_ok = 1'b1;
    run(25);
    pulse_clr();
    run(1);

    $display("scenario: word store straddling last cell");
    push(13'd4798, 32'h64636261, 2'b11);
    run(8);
    pulse_clr();
    run(2);

    $display("scenario: drain_ok stalls mid-word");
    push(13'h200, 32'h78777675, 2'b11);
    cycle();
    drain_ok = 1'b1; cycle();
    drain_ok = 1'b0; cycle();
    drain_ok = 1'b0; cycle();
    drain_ok = 1'b1; cycle();
    drain_ok = 1'b1; cycle();
    drain_ok = 1'b1; cycle();
    run(3);

    $display("scenario: half store wrapping at 0x1FFF");
    push(13'h1FFF, 32'h00005A59, 2'b10);
    run(6);
    pulse_clr();
    run(1);

    $display("scenario: reset during second byte of a word");
    push(13'h300, 32'h4D4C4B4A, 2'b11);
    push(13'h304, 32'h51504F4E, 2'b11);
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    run(8);

    $display("scenario: randomized traffic");
    verbose = 1'b0;
    wr_pct = 40; drn_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        wr_pct  = $urandom_range(10, 80);
        drn_pct = $urandom_range(30, 100);
      end
      rst      = ($urandom_range(0, 599) != 0);
      wr_en    = ($urandom_range(0, 99) < wr_pct);
      wr_size  = 2'($urandom_range(0, 3));
      wr_data  = $urandom;
      sel      = $urandom_range(0, 3);
      if (sel == 0)      wr_addr = 13'(4790 + $urandom_range(0, 15));
      else if (sel == 1) wr_addr = 13'(8186 + $urandom_range(0, 5));
      else               wr_addr = 13'($urandom_range(0, 8191));
      drain_ok = ($urandom_range(0, 99) < drn_pct);
      clr_err  = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 1'b1;
    quiet();
    drain_ok = 1'b1;
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
